// File: rtl/l2_memory_responder_if.sv
// Request/response bundle between the L1-to-L2 request path (client) and a memory responder (server).
// Carries one word-sized LOAD/STORE request and its registered response.
package l2_memory_responder_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        STORE = 2'd1
    } mem_op_e;

endpackage

interface memory_if #(
    parameter int unsigned XLEN = 32
) ();

    logic                              req_valid;
    logic [XLEN-1:0]                   req_address;
    l2_memory_responder_pkg::mem_op_e  req_operation;
    logic [XLEN-1:0]                   req_store_word;
    logic [XLEN-1:0]                   req_loaded_word;
    logic                              req_fulfilled;

    modport server (
        input  req_valid,
        input  req_address,
        input  req_operation,
        input  req_store_word,
        output req_loaded_word,
        output req_fulfilled
    );

    modport client (
        output req_valid,
        output req_address,
        output req_operation,
        output req_store_word,
        input  req_loaded_word,
        input  req_fulfilled
    );

endinterface

// File: rtl/l2_memory_responder.sv
// Fixed-latency, single-outstanding memory responder backed by a word-addressed array.
// Answers LOAD/STORE requests on memory_if and flags requester protocol violations.
module l2_memory_responder #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 4
) (
    input  logic      clk,
    input  logic      reset,
    memory_if.server  mem_if,
    output logic      busy,
    output logic      proto_err
);
    import l2_memory_responder_pkg::*;

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    mem_op_e           op_q, op_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   loaded_q, loaded_d;
    logic              fulfilled_q;
    logic              busy_q;
    logic              perr_q, perr_d;

    logic [XLEN-1:0]   mem_q [MEM_WORDS];

    logic [AW-1:0]     acc_idx;
    logic              acc_store;
    logic [XLEN-1:0]   acc_wdata;
    logic              wr_en;
    logic              mismatch;

    // Next state, latching, storage access and protocol checking
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        op_d      = op_q;
        wdata_d   = wdata_q;
        loaded_d  = loaded_q;
        perr_d    = perr_q;
        wr_en     = 1'b0;
        acc_idx   = addr_q[AW+1:2];
        acc_store = (op_q == STORE);
        acc_wdata = wdata_q;

        mismatch = !mem_if.req_valid
                || (mem_if.req_address != addr_q)
                || (mem_if.req_operation != op_q)
                || ((op_q == STORE) && (mem_if.req_store_word != wdata_q));

        case (state_q)
            ST_IDLE: begin
                if (mem_if.req_valid) begin
                    addr_d  = mem_if.req_address;
                    op_d    = mem_if.req_operation;
                    wdata_d = mem_if.req_store_word;
                    // With LATENCY==1 the access happens on the accept edge, so use live fields
                    acc_idx   = mem_if.req_address[AW+1:2];
                    acc_store = (mem_if.req_operation == STORE);
                    acc_wdata = mem_if.req_store_word;
                    cnt_d     = CNT_LOAD;
                    state_d   = (LATENCY == 1) ? ST_RESPOND : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mismatch) begin
                    perr_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESPOND: begin
                if (mismatch) begin
                    perr_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_RESPOND) begin
            wr_en    = acc_store;
            loaded_d = acc_store ? acc_wdata : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            op_q        <= LOAD;
            wdata_q     <= '0;
            loaded_q    <= '0;
            fulfilled_q <= 1'b0;
            busy_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            loaded_q    <= loaded_d;
            fulfilled_q <= (state_d == ST_RESPOND);
            busy_q      <= (state_d != ST_IDLE);
            perr_q      <= perr_d;
        end
    end

    // Storage survives reset; a reset cycle suppresses the pending write
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign mem_if.req_loaded_word = loaded_q;
    assign mem_if.req_fulfilled   = fulfilled_q;
    assign busy                   = busy_q;
    assign proto_err              = perr_q;

endmodule

// File: tb/tb_l2_memory_responder.sv
// Randomized scoreboard bench for l2_memory_responder: lane 0 runs LATENCY=4, lane 1 runs LATENCY=1.
// A transaction-level reference model predicts responses, busy and proto_err each cycle.
module tb_l2_memory_responder;
    import l2_memory_responder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_if #(.XLEN(32)) if0 ();
    memory_if #(.XLEN(32)) if1 ();

    logic        v   [2];
    logic [31:0] a   [2];
    logic [31:0] wd  [2];
    mem_op_e     op  [2];
    logic        ful [2];
    logic [31:0] rd  [2];
    logic        bsy [2];
    logic        perr[2];

    assign if0.req_valid      = v[0];
    assign if0.req_address    = a[0];
    assign if0.req_operation  = op[0];
    assign if0.req_store_word = wd[0];
    assign if1.req_valid      = v[1];
    assign if1.req_address    = a[1];
    assign if1.req_operation  = op[1];
    assign if1.req_store_word = wd[1];
    assign ful[0] = if0.req_fulfilled;
    assign rd[0]  = if0.req_loaded_word;
    assign ful[1] = if1.req_fulfilled;
    assign rd[1]  = if1.req_loaded_word;

    l2_memory_responder #(.XLEN(32), .MEM_WORDS(1024), .LATENCY(4)) dut0 (
        .clk(clk), .reset(reset), .mem_if(if0), .busy(bsy[0]), .proto_err(perr[0])
    );
    l2_memory_responder #(.XLEN(32), .MEM_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mem_if(if1), .busy(bsy[1]), .proto_err(perr[1])
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state: one pending transaction per lane
    bit          pend   [2];
    int          acc_c  [2];
    int          due_c  [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd   [2];
    mem_op_e     p_op   [2];
    bit          perr_m [2];
    logic [31:0] mdl_mem [2][1024];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int lat(input int l);
        return (l == 0) ? 4 : 1;
    endfunction

    function automatic int widx(input logic [31:0] x);
        return int'((x >> 2) % 32'd1024);
    endfunction

    function automatic int qsize(input int l);
        return (l == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(input int l, input exp_t e);
        if (l == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic exp_t qpop(input int l);
        return (l == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic void qdrop_last(input int l);
        exp_t e;
        if (l == 0) e = q0.pop_back();
        else e = q1.pop_back();
    endfunction

    function automatic int qfront_due(input int l);
        return (l == 0) ? q0[0].due : q1[0].due;
    endfunction

    function automatic void commit(input int l);
        if (p_op[l] == STORE) mdl_mem[l][widx(p_addr[l])] = p_wd[l];
    endfunction

    // Reference model: per-cycle busy/proto_err prediction, then absorb this cycle's inputs
    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            exp_t e;
            if (chk_en) begin
                chk($sformatf("busy_lane%0d", l), 32'(bsy[l]),
                    32'(pend[l] && (cyc > acc_c[l]) && (cyc <= due_c[l])));
                chk($sformatf("proto_err_lane%0d", l), 32'(perr[l]), 32'(perr_m[l]));
            end
            if (reset) begin
                if (pend[l] && due_c[l] > cyc) qdrop_last(l);
                else if (pend[l] && due_c[l] == cyc) commit(l);
                pend[l]   = 1'b0;
                perr_m[l] = 1'b0;
            end else if (pend[l]) begin
                if (!v[l] || a[l] != p_addr[l] || op[l] != p_op[l] ||
                    (p_op[l] == STORE && wd[l] != p_wd[l]))
                    perr_m[l] = 1'b1;
                if (cyc == due_c[l]) begin
                    commit(l);
                    pend[l] = 1'b0;
                end
            end else if (v[l] === 1'b1) begin
                pend[l]   = 1'b1;
                acc_c[l]  = cyc;
                due_c[l]  = cyc + lat(l);
                p_addr[l] = a[l];
                p_op[l]   = op[l];
                p_wd[l]   = wd[l];
                e.due     = due_c[l];
                e.data    = (op[l] == STORE) ? wd[l] : mdl_mem[l][widx(a[l])];
                qpush(l, e);
            end
        end
    end

    // Monitor: match every req_fulfilled pulse against the scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < 2; l++) begin
                exp_t e;
                if (ful[l] === 1'b1) begin
                    if (qsize(l) == 0) begin
                        chk($sformatf("unexpected_fulfill_lane%0d", l), 32'd1, 32'd0);
                    end else begin
                        e = qpop(l);
                        chk($sformatf("fulfill_cycle_lane%0d", l), 32'(cyc), 32'(e.due));
                        chk($sformatf("loaded_word_lane%0d", l), rd[l], e.data);
                    end
                end else if (qsize(l) > 0 && qfront_due(l) < cyc) begin
                    e = qpop(l);
                    chk($sformatf("missing_fulfill_lane%0d", l), 32'd0, 32'd1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request and hold it until the completion pulse has been seen
    task automatic req(input int l, input mem_op_e o, input logic [31:0] ad, input logic [31:0] w);
        int k;
        v[l] = 1'b1; op[l] = o; a[l] = ad; wd[l] = w;
        k = 0;
        tick(1);
        while (ful[l] !== 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
        if (k >= 50) chk($sformatf("req_timeout_lane%0d", l), 32'd0, 32'd1);
        tick(1);
        v[l] = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("%s_loaded_word_lane%0d", tag, l), rd[l], 32'd0);
            chk($sformatf("%s_fulfilled_lane%0d", tag, l), 32'(ful[l]), 32'd0);
            chk($sformatf("%s_busy_lane%0d", tag, l), 32'(bsy[l]), 32'd0);
            chk($sformatf("%s_proto_err_lane%0d", tag, l), 32'(perr[l]), 32'd0);
        end
    endtask

    // One violation of a given kind injected two cycles into a STORE on lane 0
    task automatic viol(input int kind);
        v[0] = 1'b1; op[0] = STORE; a[0] = 32'h30; wd[0] = $urandom;
        tick(2);
        case (kind)
            0:       a[0]  = 32'h34;
            1:       op[0] = LOAD;
            2:       wd[0] = ~wd[0];
            default: v[0]  = 1'b0;
        endcase
        tick(1);
        v[0] = 1'b0;
        tick(4);
        chk($sformatf("sticky_proto_err_kind%0d", kind), 32'(perr[0]), 32'd1);
        req(0, LOAD, 32'h30, 32'd0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk($sformatf("proto_err_cleared_kind%0d", kind), 32'(perr[0]), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 63)) << 2);
    endfunction

    initial begin
        for (int l = 0; l < 2; l++) begin
            v[l] = 1'b0; a[l] = '0; wd[l] = '0; op[l] = LOAD;
            pend[l] = 1'b0; perr_m[l] = 1'b0; acc_c[l] = 0; due_c[l] = 0;
        end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk_en = 1'b1;
        check_reset_state("after_reset");

        fork
            for (int i = 0; i < 64; i++) req(0, STORE, 32'(i) << 2, $urandom);
            for (int i = 0; i < 64; i++) req(1, STORE, 32'(i) << 2, $urandom);
        join

        req(0, STORE, 32'h0000_0010, 32'hDEAD_BEEF);
        req(0, LOAD,  32'h0000_0010, 32'd0);
        req(0, STORE, 32'h0000_1010, 32'h1111_2222);
        req(0, LOAD,  32'h0000_0013, 32'd0);

        // Valid held across two full transactions
        v[0] = 1'b1; op[0] = LOAD; a[0] = 32'h10;
        tick(10);
        v[0] = 1'b0;
        tick(3);

        // Reset mid-STORE: overwrite must not land
        req(0, STORE, 32'h40, 32'hDEAD_BEEF);
        v[0] = 1'b1; op[0] = STORE; a[0] = 32'h40; wd[0] = 32'hCAFE_F00D;
        tick(2);
        reset = 1'b1; v[0] = 1'b0;
        tick(1);
        reset = 1'b0;
        check_reset_state("mid_txn_reset");
        req(0, LOAD, 32'h40, 32'd0);

        for (int k = 0; k < 4; k++) viol(k);

        req(1, STORE, 32'h18, 32'hA5A5_0001);
        req(1, LOAD,  32'h18, 32'd0);
        req(1, LOAD,  32'h1C, 32'd0);

        fork
            for (int i = 0; i < 80; i++) begin
                req(0, mem_op_e'($urandom_range(0, 3)), rand_addr(), $urandom);
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            end
            for (int i = 0; i < 80; i++) begin
                req(1, mem_op_e'($urandom_range(0, 3)), rand_addr(), $urandom);
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            end
        join

        tick(8);
        chk("scoreboard_drained_lane0", 32'(q0.size()), 32'd0);
        chk("scoreboard_drained_lane1", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
